// File: rtl/int_controller_pkg.sv
// Shared constants for the interrupt controller: register map, FSM states, source limit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package int_controller_pkg;

    // int_level is 6 bits wide, which caps the number of sources.
    localparam int MAX_SRC = 6;
    // Wide enough to index any of MAX_SRC sources.
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ADDR_MASK      = 2'd0,
        ADDR_EDGE      = 2'd1,
        ADDR_PENDING   = 2'd2,
        ADDR_INSERVICE = 2'd3
    } reg_addr_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

endpackage

// File: rtl/int_controller_prio_encoder.sv
// Priority encoder: reports whether any bit is set, plus the index and one-hot of the highest set bit.
// Latency: combinational, zero cycles.
// Backpressure: none; the outputs always follow vec.
// Ports: vec (W-bit input vector) -> valid, index (IDX_W bits), onehot (W bits).
module prio_encoder
    import int_controller_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0]     vec,
    output logic             valid,
    output logic [IDX_W-1:0] index,
    output logic [W-1:0]     onehot
);

    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        // Ascending scan: the last set bit found is the highest one.
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                valid     = 1'b1;
                index     = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// Prioritised, nesting interrupt controller in front of the CPU intr/int_level/inta handshake.
// Latency: irq edge -> PENDING +1 cycle -> intr +2 cycles; inta -> intr low next cycle.
// Backpressure: a request stays held until inta or withdrawal; new candidates wait in PENDING.
// Ports: clk, rst_n (sync active-low); irq_in[NUM_SRC]; intr, int_level[6] out; inta, excp_ret in;
//        reg_addr/reg_write/reg_w_data in, reg_r_data out (MASK, EDGE, PENDING W1C, INSERVICE read-only).
module int_controller
    import int_controller_pkg::*;
#(
    parameter int NUM_SRC = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               intr,
    output logic [MAX_SRC-1:0] int_level,
    input  logic               inta,
    input  logic               excp_ret,
    input  logic [1:0]         reg_addr,
    input  logic               reg_write,
    input  logic [31:0]        reg_w_data,
    output logic [31:0]        reg_r_data
);

    logic [NUM_SRC-1:0] mask_q,     mask_d;
    logic [NUM_SRC-1:0] edge_q,     edge_d;
    logic [NUM_SRC-1:0] pend_q,     pend_d;
    logic [NUM_SRC-1:0] insvc_q,    insvc_d;
    logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_SRC-1:0] level_q,    level_d;
    state_e             state_q,    state_d;

    logic               cand_vld, svc_vld;
    logic [IDX_W-1:0]   cand_idx, svc_idx;
    logic [NUM_SRC-1:0] cand_oh,  svc_oh;
    logic [NUM_SRC-1:0] wdata;
    logic [NUM_SRC-1:0] pend_set, pend_clr;
    logic               cand_ok, req_ack, still_ok;
    logic               unused_wdata;

    assign wdata        = reg_w_data[NUM_SRC-1:0];
    assign unused_wdata = ^reg_w_data[31:NUM_SRC];

    prio_encoder #(.W(NUM_SRC)) u_cand (
        .vec    (pend_q & mask_q),
        .valid  (cand_vld),
        .index  (cand_idx),
        .onehot (cand_oh)
    );

    prio_encoder #(.W(NUM_SRC)) u_svc (
        .vec    (insvc_q),
        .valid  (svc_vld),
        .index  (svc_idx),
        .onehot (svc_oh)
    );

    always_comb begin
        mask_d     = mask_q;
        edge_d     = edge_q;
        insvc_d    = insvc_q;
        level_d    = level_q;
        state_d    = state_q;
        irq_prev_d = irq_in;

        // Only a strictly higher priority than everything in service may interrupt.
        cand_ok  = cand_vld && (!svc_vld || (cand_idx > svc_idx));
        req_ack  = (state_q == ST_REQ) && inta;
        still_ok = |(pend_q & mask_q & level_q);

        if (reg_write && (reg_addr == ADDR_MASK)) mask_d = wdata;
        if (reg_write && (reg_addr == ADDR_EDGE)) edge_d = wdata;

        // Edge bits: set by a rising edge, cleared by inta or W1C; set wins.
        // Level bits: simply track the registered request line.
        pend_set = irq_in & ~irq_prev_q;
        pend_clr = '0;
        if (req_ack) pend_clr = pend_clr | level_q;
        if (reg_write && (reg_addr == ADDR_PENDING)) pend_clr = pend_clr | wdata;
        pend_d = (edge_q & ((pend_q & ~pend_clr) | pend_set)) | (~edge_q & irq_in);

        // eret retires the old highest in-service bit before the acknowledged one is added.
        if (excp_ret && svc_vld) insvc_d = insvc_d & ~svc_oh;
        if (req_ack)             insvc_d = insvc_d | level_q;

        case (state_q)
            ST_IDLE: begin
                if (cand_ok) begin
                    state_d = ST_REQ;
                    level_d = cand_oh;
                end
            end
            ST_REQ: begin
                // level_q is frozen here; inta takes precedence over withdrawal.
                if (inta || !still_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q     <= '0;
            edge_q     <= '0;
            pend_q     <= '0;
            insvc_q    <= '0;
            irq_prev_q <= '0;
            level_q    <= '0;
            state_q    <= ST_IDLE;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            pend_q     <= pend_d;
            insvc_q    <= insvc_d;
            irq_prev_q <= irq_prev_d;
            level_q    <= level_d;
            state_q    <= state_d;
        end
    end

    assign intr = (state_q == ST_REQ);

    always_comb begin
        int_level = '0;
        if (state_q == ST_REQ) int_level[NUM_SRC-1:0] = level_q;
    end

    always_comb begin
        reg_r_data = '0;
        case (reg_addr)
            ADDR_MASK:      reg_r_data[NUM_SRC-1:0] = mask_q;
            ADDR_EDGE:      reg_r_data[NUM_SRC-1:0] = edge_q;
            ADDR_PENDING:   reg_r_data[NUM_SRC-1:0] = pend_q;
            ADDR_INSERVICE: reg_r_data[NUM_SRC-1:0] = insvc_q;
            default:        reg_r_data = '0;
        endcase
    end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_int_controller;

    logic        clk;
    logic        rst_n;
    logic [5:0]  irq_in;
    logic        intr;
    logic [5:0]  int_level;
    logic        inta;
    logic        excp_ret;
    logic [1:0]  reg_addr;
    logic        reg_write;
    logic [31:0] reg_w_data;
    logic [31:0] reg_r_data;

    int n_tests = 0;
    int n_fail  = 0;

    int_controller #(.NUM_SRC(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq_in     (irq_in),
        .intr       (intr),
        .int_level  (int_level),
        .inta       (inta),
        .excp_ret   (excp_ret),
        .reg_addr   (reg_addr),
        .reg_write  (reg_write),
        .reg_w_data (reg_w_data),
        .reg_r_data (reg_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
        reg_addr = a;
        #1;
        check(tag, reg_r_data, exp);
    endtask

    task automatic chk_out(input string tag, input logic exp_intr, input logic [5:0] exp_lvl);
        check({tag, ".intr"}, {31'd0, intr}, {31'd0, exp_intr});
        check({tag, ".lvl"},  {26'd0, int_level}, {26'd0, exp_lvl});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        reg_addr   = a;
        reg_w_data = d;
        reg_write  = 1'b1;
        tick();
        reg_write  = 1'b0;
    endtask

    // One-cycle irq pulse followed by one idle cycle: request visible afterwards.
    task automatic pulse_irq(input logic [5:0] v);
        irq_in = v;
        tick();
        irq_in = '0;
        tick();
    endtask

    task automatic do_inta();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    task automatic do_eret();
        excp_ret = 1'b1;
        tick();
        excp_ret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; irq_in = 6'h3F; inta = 1'b0; excp_ret = 1'b0;
        reg_addr = 2'd0; reg_write = 1'b0; reg_w_data = '0;

        // 1. Reset with all requests asserted.
        tick(); tick();
        chk_out("rst", 1'b0, 6'h00);
        chk_reg("rst.mask",  2'd0, 32'h0);
        chk_reg("rst.edge",  2'd1, 32'h0);
        chk_reg("rst.pend",  2'd2, 32'h0);
        chk_reg("rst.insvc", 2'd3, 32'h0);
        irq_in = '0;
        rst_n  = 1'b1;
        tick();

        // 2. Basic edge request, accept, return.
        wr(2'd0, 32'h3F);
        wr(2'd1, 32'h3F);
        chk_reg("cfg.mask", 2'd0, 32'h3F);
        irq_in = 6'h04;
        tick();
        irq_in = '0;
        chk_out("t2.n1", 1'b0, 6'h00);
        chk_reg("t2.pend", 2'd2, 32'h04);
        tick();
        chk_out("t2.n2", 1'b1, 6'h04);
        do_inta();
        chk_out("t2.ack", 1'b0, 6'h00);
        chk_reg("t2.insvc", 2'd3, 32'h04);
        chk_reg("t2.pend0", 2'd2, 32'h00);
        do_eret();
        chk_reg("t2.eret", 2'd3, 32'h00);

        // 3. Priority between simultaneous edges.
        pulse_irq(6'h12);
        chk_out("t3.first", 1'b1, 6'h10);
        do_inta();
        tick(); tick();
        chk_out("t3.blocked", 1'b0, 6'h00);
        chk_reg("t3.pend", 2'd2, 32'h02);
        do_eret();
        chk_out("t3.eret", 1'b0, 6'h00);
        tick();
        chk_out("t3.second", 1'b1, 6'h02);
        do_inta();
        chk_reg("t3.insvc", 2'd3, 32'h02);

        // 4. Nesting a higher source over [1].
        pulse_irq(6'h20);
        chk_out("t4.nest", 1'b1, 6'h20);
        do_inta();
        chk_reg("t4.insvc", 2'd3, 32'h22);
        do_eret();
        chk_reg("t4.eret1", 2'd3, 32'h02);
        do_eret();
        chk_reg("t4.eret2", 2'd3, 32'h00);
        do_eret();
        chk_reg("t4.eret0", 2'd3, 32'h00);

        // 5. Level-mode withdraw.
        wr(2'd1, 32'h00);
        wr(2'd0, 32'h08);
        irq_in = 6'h08;
        tick(); tick();
        chk_out("t5.req", 1'b1, 6'h08);
        irq_in = '0;
        tick(); tick();
        chk_out("t5.wd", 1'b0, 6'h00);
        chk_reg("t5.insvc", 2'd3, 32'h00);

        // 6a. inta and eret together.
        wr(2'd0, 32'h3F);
        wr(2'd1, 32'h3F);
        pulse_irq(6'h02);
        do_inta();
        pulse_irq(6'h20);
        chk_out("t6.req", 1'b1, 6'h20);
        inta = 1'b1; excp_ret = 1'b1;
        tick();
        inta = 1'b0; excp_ret = 1'b0;
        chk_reg("t6.insvc", 2'd3, 32'h20);
        do_eret();
        chk_reg("t6.insvc0", 2'd3, 32'h00);

        // 6b. Edge set and W1C on PENDING[0] in the same cycle.
        irq_in = 6'h01;
        wr(2'd2, 32'h01);
        irq_in = '0;
        chk_reg("t6.setwin", 2'd2, 32'h01);
        tick();
        chk_out("t6.req0", 1'b1, 6'h01);
        wr(2'd2, 32'h01);
        chk_reg("t6.w1c", 2'd2, 32'h00);
        tick();
        chk_out("t6.wd0", 1'b0, 6'h00);

        // INSERVICE is read-only.
        wr(2'd3, 32'h3F);
        chk_reg("ro.insvc", 2'd3, 32'h00);

        // Reset mid-request drops intr on the next edge.
        pulse_irq(6'h08);
        chk_out("rst2.req", 1'b1, 6'h08);
        rst_n = 1'b0;
        tick();
        chk_out("rst2", 1'b0, 6'h00);
        chk_reg("rst2.mask", 2'd0, 32'h0);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
